// File: rtl/shared_mem_rr_arbiter_pkg.sv
// Shared definitions for the shared-memory round-robin arbiter:
// FSM state encoding, default sizing and an index-width helper.
package shared_mem_pkg;

    localparam int unsigned NCORES_DEF  = 4;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MEM_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    // Width of a core index; never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_mem_rr_arbiter_picker.sv
// Combinational round-robin picker: returns the first requester found when
// scanning last_grant+1, last_grant+2, ... modulo NCORES.
module rr_priority_picker
    import shared_mem_pkg::*;
#(
    parameter int unsigned NCORES = NCORES_DEF,
    parameter int unsigned IDW    = id_width(NCORES_DEF)
) (
    input  logic [NCORES-1:0] req,
    input  logic [IDW-1:0]    last_grant,
    output logic              valid,
    output logic [IDW-1:0]    idx
);

    logic [IDW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Farthest offset first, so the nearest requester after last_grant is the final write.
        for (int unsigned k = NCORES; k >= 1; k--) begin
            cand = IDW'((32'(last_grant) + k) % NCORES);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/shared_mem_rr_arbiter.sv
// Registered round-robin arbiter between per-core shared-memory ports and a
// single shared memory; one transaction at a time, MEM_LAT-cycle hold, 1-cycle ack.
module shared_mem_rr_arbiter
    import shared_mem_pkg::*;
#(
    parameter int unsigned NCORES  = NCORES_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCORES-1:0]          core_sbit,
    input  logic [NCORES-1:0]          core_rd,
    input  logic [NCORES-1:0]          core_wr,
    input  logic [NCORES*DATA_W-1:0]   core_addr,
    input  logic [NCORES*DATA_W-1:0]   core_wdata,
    output logic [NCORES-1:0]          core_ack,
    output logic [DATA_W-1:0]          core_rdata,
    output logic [DATA_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       shared_access,
    output logic [id_width(NCORES)-1:0] grant_id
);

    localparam int unsigned IDW   = id_width(NCORES);
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                shared_q, shared_d;
    logic [NCORES-1:0]   ack_q, ack_d;

    logic [NCORES-1:0]   req;
    logic                pick_valid;
    logic [IDW-1:0]      pick_idx;
    logic [DATA_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_wr;

    assign req = core_sbit & (core_rd | core_wr);

    rr_priority_picker #(
        .NCORES (NCORES),
        .IDW    (IDW)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_addr  = core_addr[i*DATA_W +: DATA_W];
                sel_wdata = core_wdata[i*DATA_W +: DATA_W];
                sel_wr    = core_wr[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        shared_d     = shared_q;
        ack_d        = '0;

        unique case (state_q)
            IDLE: begin
                rd_d     = 1'b0;
                wr_d     = 1'b0;
                shared_d = 1'b0;
                if (pick_valid) begin
                    // Write wins when both strobes are set.
                    grant_d  = pick_idx;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    wr_d     = sel_wr;
                    rd_d     = ~sel_wr;
                    shared_d = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (rd_q) begin
                        rdata_d = mem_rdata;
                    end
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    shared_d     = 1'b0;
                    last_grant_d = grant_q;
                    for (int unsigned i = 0; i < NCORES; i++) begin
                        ack_d[i] = (grant_q == IDW'(i));
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= IDW'(NCORES - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            shared_q     <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            shared_q     <= shared_d;
            ack_q        <= ack_d;
        end
    end

    assign core_ack      = ack_q;
    assign core_rdata    = rdata_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_read      = rd_q;
    assign mem_write     = wr_q;
    assign shared_access = shared_q;
    assign grant_id      = grant_q;

endmodule

// File: tb/tb_shared_mem_rr_arbiter.sv
// Bench for shared_mem_rr_arbiter: two instances (MEM_LAT=1 and 3) share stimulus;
// a transaction-timing model is checked every cycle, plus directed literal checks.
module tb_shared_mem_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    core_sbit, core_rd, core_wr;
    logic [N*DW-1:0] core_addr, core_wdata;

    logic [N-1:0]  ack1, ack3;
    logic [DW-1:0] crd1, crd3, maddr1, maddr3, mwd1, mwd3, mrd1, mrd3;
    logic          mr1, mr3, mw1, mw3, sh1, sh3;
    logic [IW-1:0] gid1, gid3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory contents: one well-known word, everything else is the inverted address.
    function automatic logic [DW-1:0] memval(input logic [DW-1:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ~a;
    endfunction

    function automatic int unsigned lat_of(input int m);
        return (m == 0) ? 1 : 3;
    endfunction

    assign mrd1 = memval(maddr1);
    assign mrd3 = memval(maddr3);

    shared_mem_rr_arbiter #(.NCORES(N), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .core_sbit(core_sbit), .core_rd(core_rd),
        .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(ack1), .core_rdata(crd1), .mem_addr(maddr1), .mem_wdata(mwd1),
        .mem_read(mr1), .mem_write(mw1), .mem_rdata(mrd1),
        .shared_access(sh1), .grant_id(gid1)
    );

    shared_mem_rr_arbiter #(.NCORES(N), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst_n), .core_sbit(core_sbit), .core_rd(core_rd),
        .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(ack3), .core_rdata(crd3), .mem_addr(maddr3), .mem_wdata(mwd3),
        .mem_read(mr3), .mem_write(mw3), .mem_rdata(mrd3),
        .shared_access(sh3), .grant_id(gid3)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: a transaction is granted at edge 0, strobes are visible for the
    // next lat cycles (k = 0..lat-1), ack at k = lat, and at k = lat+1 the
    // arbiter is free again but only arbitrates on the following edge.
    bit            m_act   [2];
    int unsigned   m_k     [2];
    logic [IW-1:0] m_gid   [2];
    logic [IW-1:0] m_last  [2];
    logic [DW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];
    bit            m_isw   [2];

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_act[m]   <= 1'b0;
                m_k[m]     <= 0;
                m_gid[m]   <= '0;
                m_last[m]  <= IW'(N - 1);
                m_addr[m]  <= '0;
                m_wdata[m] <= '0;
                m_rdata[m] <= '0;
                m_isw[m]   <= 1'b0;
            end else if (m_act[m]) begin
                m_k[m] <= m_k[m] + 1;
                if (m_k[m] + 1 == lat_of(m)) begin
                    if (!m_isw[m]) m_rdata[m] <= memval(m_addr[m]);
                    m_last[m] <= m_gid[m];
                end
                if (m_k[m] + 1 == lat_of(m) + 1) m_act[m] <= 1'b0;
            end else begin
                automatic logic [N-1:0] req = core_sbit & (core_rd | core_wr);
                automatic bit found = 1'b0;
                for (int unsigned s = 1; s <= N; s++) begin
                    automatic int unsigned c = (32'(m_last[m]) + s) % N;
                    automatic bit hit = ((req >> c) & N'(1)) != '0;
                    if (!found && hit) begin
                        found      = 1'b1;
                        m_act[m]   <= 1'b1;
                        m_k[m]     <= 0;
                        m_gid[m]   <= IW'(c);
                        m_addr[m]  <= DW'(core_addr >> (c * DW));
                        m_wdata[m] <= DW'(core_wdata >> (c * DW));
                        m_isw[m]   <= ((core_wr >> c) & N'(1)) != '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            automatic bit            strobe = m_act[m] && (m_k[m] < lat_of(m));
            automatic logic [N-1:0]  e_ack  = (m_act[m] && m_k[m] == lat_of(m)) ? (N'(1) << m_gid[m]) : '0;
            automatic logic          e_rd   = strobe && !m_isw[m];
            automatic logic          e_wr   = strobe && m_isw[m];
            automatic logic [DW-1:0] e_addr = m_addr[m];
            automatic logic [DW-1:0] e_wd   = m_wdata[m];
            automatic logic [DW-1:0] e_rdat = m_rdata[m];
            automatic logic [IW-1:0] e_gid  = m_gid[m];
            automatic string         p      = (m == 0) ? "L1" : "L3";
            if (!rst_n) begin
                strobe = 1'b0; e_ack = '0; e_rd = 1'b0; e_wr = 1'b0;
                e_addr = '0; e_wd = '0; e_rdat = '0; e_gid = '0;
            end
            chk({p, " core_ack"},   DW'(m == 0 ? ack1 : ack3),   DW'(e_ack));
            chk({p, " mem_read"},   DW'(m == 0 ? mr1 : mr3),     DW'(e_rd));
            chk({p, " mem_write"},  DW'(m == 0 ? mw1 : mw3),     DW'(e_wr));
            chk({p, " shared"},     DW'(m == 0 ? sh1 : sh3),     DW'(strobe));
            chk({p, " mem_addr"},   (m == 0) ? maddr1 : maddr3,  e_addr);
            chk({p, " mem_wdata"},  (m == 0) ? mwd1 : mwd3,      e_wd);
            chk({p, " core_rdata"}, (m == 0) ? crd1 : crd3,      e_rdat);
            chk({p, " grant_id"},   DW'(m == 0 ? gid1 : gid3),   DW'(e_gid));
        end
    end

    task automatic drive(input logic [IW-1:0] i, input logic s, input logic r, input logic w,
                         input logic [DW-1:0] a, input logic [DW-1:0] d);
        core_sbit[i] = s;
        core_rd[i]   = r;
        core_wr[i]   = w;
        core_addr[i*DW +: DW]  = a;
        core_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear(input logic [IW-1:0] i);
        drive(i, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        core_sbit = '0; core_rd = '0; core_wr = '0; core_addr = '0; core_wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst core_ack", DW'(ack1), 32'h0);
        chk("rst grant_id", DW'(gid1), 32'h0);
        chk("rst mem_read", DW'(mr1), 32'h0);
        chk("rst core_rdata", crd1, 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single read, core 2
        drive(2'd2, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("read strobe", DW'(mr1), 32'h1);
        chk("read addr", maddr1, 32'h100);
        chk("read grant", DW'(gid1), 32'h2);
        clear(2'd2);
        @(negedge clk);
        chk("read ack", DW'(ack1), 32'h4);
        chk("read data", crd1, 32'hDEADBEEF);
        chk("L3 read still held", DW'(mr3), 32'h1);
        repeat (6) @(negedge clk);

        // Single write, core 1
        drive(2'd1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h5A5A);
        @(negedge clk);
        chk("write strobe", DW'(mw1), 32'h1);
        chk("write no read", DW'(mr1), 32'h0);
        chk("write addr", maddr1, 32'h20);
        chk("write data", mwd1, 32'h5A5A);
        clear(2'd1);
        @(negedge clk);
        chk("write ack", DW'(ack1), 32'h2);
        chk("write keeps rdata", crd1, 32'hDEADBEEF);
        repeat (6) @(negedge clk);

        // MEM_LAT=3 hold, core 3
        drive(2'd3, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        @(negedge clk);
        clear(2'd3);
        for (int c = 1; c <= 3; c++) begin
            chk("hold read", DW'(mr3), 32'h1);
            chk("hold addr", maddr3, 32'h300);
            @(negedge clk);
        end
        chk("hold ack", DW'(ack3), 32'h8);
        chk("hold strobe off", DW'(mr3), 32'h0);
        chk("hold rdata", crd3, 32'hFFFFFCFF);
        repeat (4) @(negedge clk);

        // Round robin from a fresh reset, all cores requesting
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int unsigned i = 0; i < N; i++)
            drive(IW'(i), 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0);
        repeat (2) @(negedge clk);
        chk("rr ack 0", DW'(ack1), 32'h1);
        for (int j = 1; j <= 4; j++) begin
            repeat (3) @(negedge clk);
            chk("rr ack", DW'(ack1), DW'(N'(1) << (j % 4)));
        end
        core_sbit = '0; core_rd = '0;
        repeat (8) @(negedge clk);

        // sbit=0 is never granted
        drive(2'd1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        repeat (8) begin
            @(negedge clk);
            chk("sbit0 no ack", DW'(ack1), 32'h0);
            chk("sbit0 idle", DW'(sh3), 32'h0);
        end
        clear(2'd1);

        // Reset mid-transaction drops strobes immediately
        drive(2'd2, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        chk("pre-reset strobe", DW'(mr3), 32'h1);
        clear(2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst L1 read", DW'(mr1), 32'h0);
        chk("async rst L3 read", DW'(mr3), 32'h0);
        chk("async rst shared", DW'(sh3), 32'h0);
        chk("async rst ack", DW'(ack1), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Core 0 has priority again; withdrawn request still acked
        drive(2'd0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(2'd1, 1'b1, 1'b0, 1'b1, 32'h14, 32'h77);
        @(negedge clk);
        chk("post-rst grant L1", DW'(gid1), 32'h0);
        chk("post-rst grant L3", DW'(gid3), 32'h0);
        clear(2'd0);
        @(negedge clk);
        chk("withdrawn ack", DW'(ack1), 32'h1);
        clear(2'd1);
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
